mem_access_adapter: RTL and testbench
=====================================

Name: mem_access_adapter

Overview:
- Sits directly upstream of the DDR3 RAM controller, between the RISC-V core's load/store unit and the controller's single-word trigger/ready interface.
- Converts byte, halfword and word loads/stores at any byte address into one or two aligned 32-bit RAM operations with byte masks.
- Merges split read data and sign/zero-extends loads.
- Returns one response pulse per core request.

Parameters:
- ADDRESS_SIZE, 28, width of the RAM-side address in bytes; low 2 bits are always driven 0.
- DATA_SIZE, 32, RAM word width; fixed at 32.
- MASK_SIZE, DATA_SIZE/8, byte-enable width.

Ports:
- clk  in  1  single clock; core side and RAM-controller side both run on it.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  adapter can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_address  in  ADDRESS_SIZE  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_error  out  1  valid with resp_valid.
- ram_address  out  ADDRESS_SIZE  word-aligned byte address.
- ram_mask  out  MASK_SIZE  bit i enables byte lane i.
- ram_write_trigger  out  1  one-cycle write request.
- ram_write_value  out  32  lane-positioned write data.
- ram_read_trigger  out  1  one-cycle read request.
- ram_read_value  in  32  read word, valid when controller_ready returns high.
- ram_controller_ready  in  1  controller idle.
- ram_error  in  4  controller error code; nonzero means failure.

Behaviour:
- **Reset (async, rst_n=0):**
  - State goes to IDLE.
  - All outputs 0, except req_ready=1.
  - A reset mid-operation drops the request with no response. The controller may still finish its word.
- **Request capture:**
  - Accept on clk edge when req_valid && req_ready.
  - Latch all req_* fields.
  - Compute off = addr[1:0] and bytes = 1 << size.
  - The access is split when off + bytes > 4.
- **FSM: IDLE -> ISSUE0 -> WAIT0 -> [ISSUE1 -> WAIT1] -> RESP -> IDLE.**
- **ISSUE phases:**
  - Wait for ram_controller_ready=1, then pulse exactly one trigger for one cycle.
  - Never assert both triggers at once.
  - ram_address, ram_mask and ram_write_value are held stable from the issue cycle until the WAIT phase ends.
- **WAIT phases:**
  - Ignore the first cycle after the trigger; the controller's ready drops one cycle late.
  - Then wait for ram_controller_ready=1.
  - On that cycle, capture ram_read_value for reads and sample ram_error.
- **First word:**
  - Address = {addr[ADDRESS_SIZE-1:2], 2'b00}.
  - mask0 = ((1 << bytes) - 1) << off, truncated to 4 bits.
  - wvalue0 = wdata << (8*off).
- **Second word (split only):**
  - Address = first address + 4, wrapping modulo 2^ADDRESS_SIZE.
  - mask1 = ((1 << bytes) - 1) >> (4 - off).
  - wvalue1 = wdata >> (8*(4 - off)).
- **Loads:**
  - Form the 64-bit value {word1, word0}, shift right by 8*off, then take the low 8/16/32 bits.
  - Sign- or zero-extend per req_unsigned.
- **RESP:**
  - resp_valid=1 for exactly one cycle; resp_rdata and resp_error are valid in that cycle.
  - Return to IDLE on the next cycle.
- **Errors:**
  - req_size=3: go straight to RESP with resp_error=1 and no RAM access.
  - ram_error != 0 in any WAIT phase: skip the remaining word and go to RESP with resp_error=1. For a load, resp_rdata=0.
- **Latency:**
  - Fastest unsplit access: 1 (ISSUE) + controller time + 1 (RESP) cycles.
  - Request accept to the first trigger is 1 cycle when the controller is ready.
  - req_valid held high while req_ready=0 has no effect.

Optional Feature:
- Macro: MEM_ACCESS_ADAPTER_MISALIGNED_SPLIT_EN.
- Defined: split accesses are performed as described above.
- Undefined:
  - Any access with off + bytes > 4 goes directly to RESP with resp_error=1 and no triggers.
  - The ISSUE1/WAIT1 states and the 64-bit merge are not built.

Test Plan:
- **SW, aligned:** addr=0x100, wdata=0xDEADBEEF -> one write trigger; ram_address=0x100, mask=4'b1111, value=0xDEADBEEF; resp_valid with error=0.
- **LB, signed:** addr=0x203, RAM word 0x80112233 -> one read at 0x200; resp_rdata=0xFFFFFF80. Repeat with req_unsigned=1 -> 0x00000080.
- **SH, split:** addr=0x303, wdata=0xAABB ->
  - write 1: 0x300, mask=4'b1000, lane 3=0xBB;
  - write 2: 0x304, mask=4'b0001, lane 0=0xAA.
  - Without the macro: resp_error=1 and no triggers.
- **LW, split:** addr=0x402, words 0x44332211 @0x400 and 0x88776655 @0x404 -> resp_rdata=0x66554433.
- **Error and illegal size:**
  - ram_error=1 returned on the first word of a split read -> no second trigger; resp_error=1, resp_rdata=0.
  - req_size=3 -> resp_error=1 with no triggers.
- **Reset mid-WAIT:** rst_n low -> outputs 0 immediately, req_ready=1; the next request proceeds normally.

Source files
------------

// File: rtl/mem_access_adapter.sv
// Splits core byte/half/word loads and stores into one or two masked 32-bit RAM operations, then merges and extends the returned load data.
// Latency: request accept to first trigger is 1 cycle when the controller is ready; the response pulse follows the last word by 1 cycle. One request at a time.
// Backpressure: req_ready is high only in IDLE; each issue waits for ram_controller_ready. Split support is enabled by MEM_ACCESS_ADAPTER_MISALIGNED_SPLIT_EN.
module mem_access_adapter #(
  parameter int ADDRESS_SIZE = 28,
  parameter int DATA_SIZE    = 32,
  parameter int MASK_SIZE    = DATA_SIZE / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDRESS_SIZE-1:0] req_address,
  input  logic [DATA_SIZE-1:0]    req_wdata,
  output logic                    resp_valid,
  output logic [DATA_SIZE-1:0]    resp_rdata,
  output logic                    resp_error,
  output logic [ADDRESS_SIZE-1:0] ram_address,
  output logic [MASK_SIZE-1:0]    ram_mask,
  output logic                    ram_write_trigger,
  output logic [DATA_SIZE-1:0]    ram_write_value,
  output logic                    ram_read_trigger,
  input  logic [DATA_SIZE-1:0]    ram_read_value,
  input  logic                    ram_controller_ready,
  input  logic [3:0]              ram_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE0,
    S_WAIT0,
`ifdef MEM_ACCESS_ADAPTER_MISALIGNED_SPLIT_EN
    S_ISSUE1,
    S_WAIT1,
`endif
    S_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic                    write_q, write_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [1:0]              off_q, off_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    skip_q, skip_d;
`ifdef MEM_ACCESS_ADAPTER_MISALIGNED_SPLIT_EN
  logic                    split_q, split_d;
  logic [31:0]             word0_q, word0_d;
`endif

  logic                    req_ready_q, req_ready_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [31:0]             resp_rdata_q, resp_rdata_d;
  logic                    resp_error_q, resp_error_d;
  logic [ADDRESS_SIZE-1:0] ram_address_q, ram_address_d;
  logic [3:0]              ram_mask_q, ram_mask_d;
  logic                    ram_write_trigger_q, ram_write_trigger_d;
  logic [31:0]             ram_write_value_q, ram_write_value_d;
  logic                    ram_read_trigger_q, ram_read_trigger_d;

  logic [3:0]  req_span;
  logic        req_split;
  logic [3:0]  size_lanes;
  logic [3:0]  mask0;
  logic [31:0] wval0;
  logic [31:0] ld_word;
  logic [31:0] ld_ext;

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] sz,
                                         input logic uns);
    case (sz)
      2'd0:    extend = {{24{~uns & w[7]}}, w[7:0]};
      2'd1:    extend = {{16{~uns & w[15]}}, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  assign req_span   = {2'b00, req_address[1:0]} + (4'd1 << req_size);
  assign req_split  = (req_span > 4'd4);
  assign size_lanes = (size_q == 2'd0) ? 4'b0001 : (size_q == 2'd1) ? 4'b0011 : 4'b1111;
  assign mask0      = 4'(({4'b0000, size_lanes}) << off_q);
  assign wval0      = 32'(({32'd0, wdata_q}) << {off_q, 3'b000});

`ifdef MEM_ACCESS_ADAPTER_MISALIGNED_SPLIT_EN
  logic [3:0]  mask1;
  logic [31:0] wval1;
  logic [31:0] ld_lo;
  logic [31:0] ld_hi;
  assign mask1   = 4'((({4'b0000, size_lanes}) << off_q) >> 4);
  assign wval1   = 32'(((({32'd0, wdata_q}) << {off_q, 3'b000})) >> 32);
  // The first word is live on the bus in WAIT0, but only the latched copy survives into WAIT1.
  assign ld_lo   = (state_q == S_WAIT0) ? ram_read_value : word0_q;
  assign ld_hi   = (state_q == S_WAIT1) ? ram_read_value : 32'd0;
  assign ld_word = 32'(({ld_hi, ld_lo}) >> {off_q, 3'b000});
`else
  assign ld_word = ram_read_value >> {off_q, 3'b000};
`endif
  assign ld_ext = extend(ld_word, size_q, uns_q);

  always_comb begin
    state_d             = state_q;
    write_d             = write_q;
    size_d              = size_q;
    uns_d               = uns_q;
    addr_d              = addr_q;
    off_d               = off_q;
    wdata_d             = wdata_q;
    skip_d              = skip_q;
`ifdef MEM_ACCESS_ADAPTER_MISALIGNED_SPLIT_EN
    split_d             = split_q;
    word0_d             = word0_q;
`endif
    ram_address_d       = ram_address_q;
    ram_mask_d          = ram_mask_q;
    ram_write_value_d   = ram_write_value_q;
    ram_write_trigger_d = 1'b0;
    ram_read_trigger_d  = 1'b0;
    resp_rdata_d        = resp_rdata_q;
    resp_error_d        = resp_error_q;

    case (state_q)
      S_IDLE: begin
        resp_rdata_d = 32'd0;
        resp_error_d = 1'b0;
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = {req_address[ADDRESS_SIZE-1:2], 2'b00};
          off_d   = req_address[1:0];
          wdata_d = req_wdata;
`ifdef MEM_ACCESS_ADAPTER_MISALIGNED_SPLIT_EN
          split_d = req_split;
          if (req_size == 2'd3) begin
`else
          if (req_size == 2'd3 || req_split) begin
`endif
            state_d      = S_RESP;
            resp_error_d = 1'b1;
          end else begin
            state_d = S_ISSUE0;
          end
        end
      end
      S_ISSUE0: begin
        if (ram_controller_ready) begin
          ram_address_d       = addr_q;
          ram_mask_d          = mask0;
          ram_write_value_d   = wval0;
          ram_write_trigger_d = write_q;
          ram_read_trigger_d  = ~write_q;
          skip_d              = 1'b1;
          state_d             = S_WAIT0;
        end
      end
      S_WAIT0: begin
        // Controller ready is still high in the trigger cycle, so that cycle is ignored.
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (ram_controller_ready) begin
          if (ram_error != 4'd0) begin
            state_d      = S_RESP;
            resp_error_d = 1'b1;
            resp_rdata_d = 32'd0;
`ifdef MEM_ACCESS_ADAPTER_MISALIGNED_SPLIT_EN
          end else if (split_q) begin
            word0_d = ram_read_value;
            state_d = S_ISSUE1;
`endif
          end else begin
            state_d      = S_RESP;
            resp_rdata_d = write_q ? 32'd0 : ld_ext;
          end
        end
      end
`ifdef MEM_ACCESS_ADAPTER_MISALIGNED_SPLIT_EN
      S_ISSUE1: begin
        if (ram_controller_ready) begin
          ram_address_d       = addr_q + ADDRESS_SIZE'(32'd4);
          ram_mask_d          = mask1;
          ram_write_value_d   = wval1;
          ram_write_trigger_d = write_q;
          ram_read_trigger_d  = ~write_q;
          skip_d              = 1'b1;
          state_d             = S_WAIT1;
        end
      end
      S_WAIT1: begin
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (ram_controller_ready) begin
          state_d = S_RESP;
          if (ram_error != 4'd0) begin
            resp_error_d = 1'b1;
            resp_rdata_d = 32'd0;
          end else begin
            resp_rdata_d = write_q ? 32'd0 : ld_ext;
          end
        end
      end
`endif
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= S_IDLE;
      write_q             <= 1'b0;
      size_q              <= 2'd0;
      uns_q               <= 1'b0;
      addr_q              <= '0;
      off_q               <= 2'd0;
      wdata_q             <= 32'd0;
      skip_q              <= 1'b0;
`ifdef MEM_ACCESS_ADAPTER_MISALIGNED_SPLIT_EN
      split_q             <= 1'b0;
      word0_q             <= 32'd0;
`endif
      req_ready_q         <= 1'b1;
      resp_valid_q        <= 1'b0;
      resp_rdata_q        <= 32'd0;
      resp_error_q        <= 1'b0;
      ram_address_q       <= '0;
      ram_mask_q          <= 4'd0;
      ram_write_trigger_q <= 1'b0;
      ram_write_value_q   <= 32'd0;
      ram_read_trigger_q  <= 1'b0;
    end else begin
      state_q             <= state_d;
      write_q             <= write_d;
      size_q              <= size_d;
      uns_q               <= uns_d;
      addr_q              <= addr_d;
      off_q               <= off_d;
      wdata_q             <= wdata_d;
      skip_q              <= skip_d;
`ifdef MEM_ACCESS_ADAPTER_MISALIGNED_SPLIT_EN
      split_q             <= split_d;
      word0_q             <= word0_d;
`endif
      req_ready_q         <= req_ready_d;
      resp_valid_q        <= resp_valid_d;
      resp_rdata_q        <= resp_rdata_d;
      resp_error_q        <= resp_error_d;
      ram_address_q       <= ram_address_d;
      ram_mask_q          <= ram_mask_d;
      ram_write_trigger_q <= ram_write_trigger_d;
      ram_write_value_q   <= ram_write_value_d;
      ram_read_trigger_q  <= ram_read_trigger_d;
    end
  end

  assign req_ready         = req_ready_q;
  assign resp_valid        = resp_valid_q;
  assign resp_rdata        = resp_rdata_q;
  assign resp_error        = resp_error_q;
  assign ram_address       = ram_address_q;
  assign ram_mask          = ram_mask_q;
  assign ram_write_trigger = ram_write_trigger_q;
  assign ram_write_value   = ram_write_value_q;
  assign ram_read_trigger  = ram_read_trigger_q;

endmodule

// File: tb/tb_mem_access_adapter.sv
// Directed bench for mem_access_adapter: a DDR-controller stand-in checks every RAM trigger
// against queued expectations, and a response monitor pops queued expected responses.
module tb_mem_access_adapter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [27:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [27:0] ram_address;
  logic [3:0]  ram_mask;
  logic        ram_write_trigger;
  logic [31:0] ram_write_value;
  logic        ram_read_trigger;
  logic [31:0] ram_read_value;
  logic        ram_controller_ready;
  logic [3:0]  ram_error;

  mem_access_adapter dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_write            (req_write),
    .req_size             (req_size),
    .req_unsigned         (req_unsigned),
    .req_address          (req_address),
    .req_wdata            (req_wdata),
    .resp_valid           (resp_valid),
    .resp_rdata           (resp_rdata),
    .resp_error           (resp_error),
    .ram_address          (ram_address),
    .ram_mask             (ram_mask),
    .ram_write_trigger    (ram_write_trigger),
    .ram_write_value      (ram_write_value),
    .ram_read_trigger     (ram_read_trigger),
    .ram_read_value       (ram_read_value),
    .ram_controller_ready (ram_controller_ready),
    .ram_error            (ram_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    bit          wr;
    logic [27:0] addr;
    logic [3:0]  mask;
    logic [31:0] val;
  } ram_op_t;

  typedef struct {
    string       nm;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  ram_op_t     ram_q[$];
  resp_t       resp_q[$];
  logic [31:0] mem [logic [27:0]];

  int n_vec = 0;
  int n_err = 0;
  int resp_seen = 0;
  int trig_seen = 0;
  int lat = 2;
  bit inject_err = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_wr(input string nm, input logic [27:0] a, input logic [3:0] m,
                        input logic [31:0] v);
    ram_op_t op;
    op.nm = nm; op.wr = 1'b1; op.addr = a; op.mask = m; op.val = v;
    ram_q.push_back(op);
  endtask

  task automatic exp_rd(input string nm, input logic [27:0] a, input logic [3:0] m);
    ram_op_t op;
    op.nm = nm; op.wr = 1'b0; op.addr = a; op.mask = m; op.val = 32'd0;
    ram_q.push_back(op);
  endtask

  // Controller stand-in: drives its outputs on the falling edge.
  initial begin
    bit          busy;
    int          cnt;
    bit          pend_wr;
    logic [27:0] pend_addr;
    logic [31:0] old;
    ram_op_t     op;
    busy = 1'b0; cnt = 0; pend_wr = 1'b0; pend_addr = '0;
    ram_controller_ready = 1'b1;
    ram_read_value = 32'd0;
    ram_error = 4'd0;
    forever begin
      @(negedge clk);
      if (ram_write_trigger === 1'b1 && ram_read_trigger === 1'b1) begin
        n_vec++; n_err++;
        $display("FAIL both_triggers: got write=1 read=1, expected at most one");
      end
      if (busy) begin
        if (cnt == 0) begin
          busy = 1'b0;
          ram_controller_ready = 1'b1;
          ram_read_value = (!pend_wr && mem.exists(pend_addr)) ? mem[pend_addr] : 32'd0;
          ram_error = inject_err ? 4'h1 : 4'h0;
          inject_err = 1'b0;
        end else begin
          cnt--;
        end
      end else if (ram_write_trigger === 1'b1 || ram_read_trigger === 1'b1) begin
        trig_seen++;
        if (ram_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_trigger: got write=%0b addr=%0h mask=%0h, expected none",
                   ram_write_trigger, ram_address, ram_mask);
        end else begin
          op = ram_q.pop_front();
          chk({op.nm, "_is_write"}, 64'(ram_write_trigger), 64'(op.wr));
          chk({op.nm, "_addr"}, 64'(ram_address), 64'(op.addr));
          chk({op.nm, "_mask"}, 64'(ram_mask), 64'(op.mask));
          if (op.wr) chk({op.nm, "_wvalue"}, 64'(ram_write_value), 64'(op.val));
        end
        if (ram_write_trigger === 1'b1) begin
          old = mem.exists(ram_address) ? mem[ram_address] : 32'd0;
          for (int i = 0; i < 4; i++)
            if (ram_mask[i]) old[8*i +: 8] = ram_write_value[8*i +: 8];
          mem[ram_address] = old;
        end
        pend_wr = ram_write_trigger;
        pend_addr = ram_address;
        busy = 1'b1;
        cnt = lat;
        ram_controller_ready = 1'b0;
        ram_error = 4'd0;
      end
    end
  end

  // Response monitor.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        resp_seen++;
        if (resp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_resp: got rdata=%0h err=%0b, expected no response",
                   resp_rdata, resp_error);
        end else begin
          r = resp_q.pop_front();
          chk({r.nm, "_rdata"}, 64'(resp_rdata), 64'(r.rdata));
          chk({r.nm, "_error"}, 64'(resp_error), 64'(r.err));
        end
      end
    end
  end

  task automatic drive_req(input string nm, input bit wr, input logic [1:0] sz, input bit uns,
                           input logic [27:0] a, input logic [31:0] wd);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk({nm, "_req_ready_timeout"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_address = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic do_req(input string nm, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [27:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee);
    resp_t r;
    int    start;
    int    n;
    r.nm = nm; r.rdata = er; r.err = ee;
    resp_q.push_back(r);
    start = resp_seen;
    drive_req(nm, wr, sz, uns, a, wd);
    n = 0;
    while (resp_seen == start && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (resp_seen == start) chk({nm, "_resp_timeout"}, 64'(resp_seen - start), 64'd1);
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({nm, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({nm, "_resp_rdata"}, 64'(resp_rdata), 64'd0);
    chk({nm, "_resp_error"}, 64'(resp_error), 64'd0);
    chk({nm, "_ram_address"}, 64'(ram_address), 64'd0);
    chk({nm, "_ram_mask"}, 64'(ram_mask), 64'd0);
    chk({nm, "_ram_wr_trig"}, 64'(ram_write_trigger), 64'd0);
    chk({nm, "_ram_wr_value"}, 64'(ram_write_value), 64'd0);
    chk({nm, "_ram_rd_trig"}, 64'(ram_read_trigger), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int n;
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_address = '0; req_wdata = 32'd0;
    mem[28'h200] = 32'h80112233;
    mem[28'h300] = 32'h11223344;
    mem[28'h400] = 32'h44332211;
    mem[28'h404] = 32'h88776655;
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    exp_wr("sw_aligned", 28'h100, 4'b1111, 32'hDEADBEEF);
    do_req("sw_aligned", 1'b1, 2'd2, 1'b0, 28'h100, 32'hDEADBEEF, 32'd0, 1'b0);

    exp_rd("lb_signed", 28'h200, 4'b1000);
    do_req("lb_signed", 1'b0, 2'd0, 1'b0, 28'h203, 32'd0, 32'hFFFFFF80, 1'b0);
    exp_rd("lb_unsigned", 28'h200, 4'b1000);
    do_req("lb_unsigned", 1'b0, 2'd0, 1'b1, 28'h203, 32'd0, 32'h00000080, 1'b0);

    exp_rd("lh_signed", 28'h404, 4'b1100);
    do_req("lh_signed", 1'b0, 2'd1, 1'b0, 28'h406, 32'd0, 32'hFFFF8877, 1'b0);
    exp_rd("lh_unsigned", 28'h404, 4'b1100);
    do_req("lh_unsigned", 1'b0, 2'd1, 1'b1, 28'h406, 32'd0, 32'h00008877, 1'b0);

    exp_wr("sb_off1", 28'h500, 4'b0010, 32'h34567700);
    do_req("sb_off1", 1'b1, 2'd0, 1'b0, 28'h501, 32'h12345677, 32'd0, 1'b0);
    exp_rd("lw_after_sb", 28'h500, 4'b1111);
    do_req("lw_after_sb", 1'b0, 2'd2, 1'b0, 28'h500, 32'd0, 32'h00007700, 1'b0);

`ifdef MEM_ACCESS_ADAPTER_MISALIGNED_SPLIT_EN
    exp_wr("sh_split_w0", 28'h300, 4'b1000, 32'hBB000000);
    exp_wr("sh_split_w1", 28'h304, 4'b0001, 32'h000000AA);
    do_req("sh_split", 1'b1, 2'd1, 1'b0, 28'h303, 32'h0000AABB, 32'd0, 1'b0);
    exp_rd("lw_after_sh", 28'h300, 4'b1111);
    do_req("lw_after_sh", 1'b0, 2'd2, 1'b0, 28'h300, 32'd0, 32'hBB223344, 1'b0);

    exp_rd("lw_split_r0", 28'h400, 4'b1100);
    exp_rd("lw_split_r1", 28'h404, 4'b0011);
    do_req("lw_split", 1'b0, 2'd2, 1'b0, 28'h402, 32'd0, 32'h66554433, 1'b0);

    exp_wr("sh_wrap_w0", 28'hFFFFFFC, 4'b1000, 32'hD4000000);
    exp_wr("sh_wrap_w1", 28'h0000000, 4'b0001, 32'h000000C3);
    do_req("sh_wrap", 1'b1, 2'd1, 1'b0, 28'hFFFFFFF, 32'h0000C3D4, 32'd0, 1'b0);
    exp_rd("lh_wrap_r0", 28'hFFFFFFC, 4'b1000);
    exp_rd("lh_wrap_r1", 28'h0000000, 4'b0001);
    do_req("lh_wrap", 1'b0, 2'd1, 1'b0, 28'hFFFFFFF, 32'd0, 32'hFFFFC3D4, 1'b0);

    exp_rd("lw_split_err_r0", 28'h400, 4'b1100);
    inject_err = 1'b1;
    do_req("lw_split_err", 1'b0, 2'd2, 1'b0, 28'h402, 32'd0, 32'd0, 1'b1);
`else
    do_req("sh_split_off", 1'b1, 2'd1, 1'b0, 28'h303, 32'h0000AABB, 32'd0, 1'b1);
    exp_rd("lw_after_sh", 28'h300, 4'b1111);
    do_req("lw_after_sh", 1'b0, 2'd2, 1'b0, 28'h300, 32'd0, 32'h11223344, 1'b0);
    do_req("lw_split_off", 1'b0, 2'd2, 1'b0, 28'h402, 32'd0, 32'd0, 1'b1);
    do_req("sh_wrap_off", 1'b1, 2'd1, 1'b0, 28'hFFFFFFF, 32'h0000C3D4, 32'd0, 1'b1);
`endif

    exp_rd("lw_err", 28'h400, 4'b1111);
    inject_err = 1'b1;
    do_req("lw_err", 1'b0, 2'd2, 1'b0, 28'h400, 32'd0, 32'd0, 1'b1);

    do_req("size3_load", 1'b0, 2'd3, 1'b0, 28'h500, 32'd0, 32'd0, 1'b1);
    do_req("size3_store", 1'b1, 2'd3, 1'b0, 28'h500, 32'h01020304, 32'd0, 1'b1);

    // Reset while the adapter waits on a slow controller: the request is dropped silently.
    lat = 6;
    exp_rd("midrst_r0", 28'h400, 4'b1111);
    start = trig_seen;
    drive_req("midrst", 1'b0, 2'd2, 1'b0, 28'h400, 32'd0);
    n = 0;
    while (trig_seen == start && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_trigger_seen", 64'(trig_seen - start), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    lat = 2;

    exp_rd("after_rst", 28'h400, 4'b1111);
    do_req("after_rst", 1'b0, 2'd2, 1'b0, 28'h400, 32'd0, 32'h44332211, 1'b0);

    repeat (10) @(negedge clk);
    chk("ram_ops_outstanding", 64'(ram_q.size()), 64'd0);
    chk("resp_outstanding", 64'(resp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
